// File: rtl/dot_pkg.sv
// Shared constants, row type and FSM state encoding for the dot-map reader.
package dot_pkg;
  localparam int NUM_ROWS   = 12;
  localparam int NUM_COLS   = 12;
  localparam int TOTAL_DOTS = 144;

  localparam logic [3:0] LAST_ROW     = 4'(NUM_ROWS - 1);
  localparam logic [7:0] TOTAL_DOTS_B = 8'(TOTAL_DOTS);

  typedef logic [NUM_COLS-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FIN  = 2'd2
  } state_t;
endpackage

// File: rtl/dot_row_popcount.sv
// Combinational popcount of one 12-bit dot-map row (0..12).
module dot_row_popcount
  import dot_pkg::*;
(
  input  row_t       row,
  output logic [3:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      count = count + {3'b000, row[i]};
    end
  end

endmodule

// File: rtl/dot_map_reader.sv
// Scans all 12 rows of the dot store on start and reports dots left / eaten.
// Optional rd_ack timeout is enabled by defining DOT_MAP_READER_TIMEOUT_EN.
module dot_map_reader
  import dot_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic        start,
  output logic        rd_req,
  output logic [3:0]  rd_row,
  input  logic        rd_ack,
  input  logic [11:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  dots_left,
  output logic [7:0]  eaten,
  output logic        level_clear,
  output logic        timeout_err
);

  // state | meaning
  // IDLE  | waiting for start; results of last scan held
  // REQ   | rd_req high for rd_row, waiting for rd_ack
  // FIN   | one cycle: latch results, done pulses next cycle

  state_t     state_q, state_d;
  logic [3:0] row_q;
  logic [7:0] acc_q;
  logic [3:0] row_count;
  logic       done_q;
  logic       level_clear_q;
  logic [7:0] dots_left_q;
  logic [7:0] eaten_q;
  logic       start_ok;
  logic       ack_ok;
  logic       timeout_hit;

  assign start_ok = (state_q == IDLE) && start;
  assign ack_ok   = (state_q == REQ) && rd_ack;

  dot_row_popcount u_popcount (
    .row   (rd_data),
    .count (row_count)
  );

`ifdef DOT_MAP_READER_TIMEOUT_EN
  localparam int                WAIT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ACK_TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_q;
  logic              err_q;

  // Down-counter reloads on every accepted row; terminal count without ack aborts the scan.
  assign timeout_hit = (state_q == REQ) && !rd_ack && (wait_q == '0);

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_q <= WAIT_LOAD;
      err_q  <= 1'b0;
    end else begin
      if (start_ok || ack_ok) begin
        wait_q <= WAIT_LOAD;
      end else if ((state_q == REQ) && (wait_q != '0)) begin
        wait_q <= wait_q - 1'b1;
      end
      if (start_ok) begin
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ: begin
        if (rd_ack) begin
          if (row_q == LAST_ROW) state_d = FIN;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      row_q         <= '0;
      acc_q         <= '0;
      done_q        <= 1'b0;
      dots_left_q   <= TOTAL_DOTS_B;
      eaten_q       <= '0;
      level_clear_q <= 1'b0;
    end else begin
      done_q <= (state_q == FIN);
      if (start_ok) begin
        row_q <= '0;
        acc_q <= '0;
      end else if (ack_ok) begin
        acc_q <= acc_q + {4'b0000, row_count};
        if (row_q != LAST_ROW) row_q <= row_q + 4'd1;
      end
      // Results are only published here, so aborted scans leave them untouched.
      if (state_q == FIN) begin
        dots_left_q   <= acc_q;
        eaten_q       <= TOTAL_DOTS_B - acc_q;
        level_clear_q <= (acc_q == 8'd0);
      end
    end
  end

  assign rd_req      = (state_q == REQ);
  assign rd_row      = row_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign dots_left   = dots_left_q;
  assign eaten       = eaten_q;
  assign level_clear = level_clear_q;

endmodule

// File: tb/tb_dot_map_reader.sv
// Directed, table-driven bench for dot_map_reader (timeout case when DOT_MAP_READER_TIMEOUT_EN is defined).
module tb_dot_map_reader;
  import dot_pkg::*;

  logic        frame_clk = 1'b0;
  logic        Reset_n   = 1'b0;
  logic        start     = 1'b0;
  logic        rd_req;
  logic [3:0]  rd_row;
  logic        rd_ack;
  logic [11:0] rd_data;
  logic        busy;
  logic        done;
  logic [7:0]  dots_left;
  logic [7:0]  eaten;
  logic        level_clear;
  logic        timeout_err;

  dot_map_reader #(.ACK_TIMEOUT(16)) dut (
    .frame_clk   (frame_clk),
    .Reset_n     (Reset_n),
    .start       (start),
    .rd_req      (rd_req),
    .rd_row      (rd_row),
    .rd_ack      (rd_ack),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .dots_left   (dots_left),
    .eaten       (eaten),
    .level_clear (level_clear),
    .timeout_err (timeout_err)
  );

  always #5 frame_clk = ~frame_clk;

  // Dot store model: acks immediately except on stall_row, which waits stall_len cycles.
  logic [11:0] map_mem [12];
  int          stall_row = -1;
  int          stall_len = 0;
  int          wait_cnt  = 0;
  logic        force_ack = 1'b0;

  assign rd_ack  = force_ack | (rd_req && ((int'(rd_row) != stall_row) || (wait_cnt >= stall_len)));
  assign rd_data = (rd_row < 4'd12) ? map_mem[rd_row] : 12'h000;

  always @(posedge frame_clk) begin
    if (rd_req && !rd_ack) wait_cnt <= wait_cnt + 1;
    else                   wait_cnt <= 0;
  end

  int         checks   = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         rows_q[$];
  bit         hold_ok  = 1'b1;
  logic       prev_wait = 1'b0;
  logic [3:0] prev_row  = '0;

  always @(negedge frame_clk) begin
    if (done) done_cnt = done_cnt + 1;
    if (rd_req && rd_ack) rows_q.push_back(int'(rd_row));
    if (prev_wait && rd_req && (rd_row != prev_row)) hold_ok = 1'b0;
`ifndef DOT_MAP_READER_TIMEOUT_EN
    if (prev_wait && !rd_req && Reset_n) hold_ok = 1'b0;
`endif
    prev_wait = rd_req && !rd_ack;
    prev_row  = rd_row;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [11:0] even_row;
    logic [11:0] odd_row;
    int          ovr_row;
    logic [11:0] ovr_val;
    int          st_row;
    int          st_len;
    int          exp_dots;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic load_map(input logic [11:0] ev, input logic [11:0] od, input int ovr, input logic [11:0] ov);
    for (int r = 0; r < 12; r++) map_mem[r] = (r % 2 == 0) ? ev : od;
    if (ovr >= 0) map_mem[ovr] = ov;
  endtask

  task automatic run_scan(input string tag, input int exp_dots, input int exp_lat, input bit stray_start);
    int  lat;
    int  d0;
    bit  seq_ok;
    rows_q.delete();
    hold_ok = 1'b1;
    d0  = done_cnt;
    lat = -1;
    @(negedge frame_clk);
    start = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge frame_clk);
      start = stray_start && (i == 4);
      if (i == 1) begin
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_terr_clr"}, timeout_err, 0);
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge frame_clk);
    seq_ok = (rows_q.size() == 12);
    foreach (rows_q[k]) if (rows_q[k] != k) seq_ok = 1'b0;
    chk({tag, "_latency"},  lat, exp_lat);
    chk({tag, "_done_cnt"}, done_cnt - d0, 1);
    chk({tag, "_dots"},     dots_left, exp_dots);
    chk({tag, "_eaten"},    eaten, 144 - exp_dots);
    chk({tag, "_lclear"},   level_clear, (exp_dots == 0) ? 1 : 0);
    chk({tag, "_idle"},     busy, 0);
    chk({tag, "_rowseq"},   seq_ok, 1);
    chk({tag, "_hold"},     hold_ok, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    bit found;

    vecs[0] = '{"full",   12'hfff, 12'hfff, -1, 12'h000, -1, 0, 144, 14};
    vecs[1] = '{"empty",  12'h000, 12'h000, -1, 12'h000, -1, 0,   0, 14};
    vecs[2] = '{"sparse", 12'h001, 12'h800, -1, 12'h000, -1, 0,  12, 14};
    vecs[3] = '{"checker",12'ha5a, 12'h5a5, -1, 12'h000, -1, 0,  72, 14};
    vecs[4] = '{"stall3", 12'hfff, 12'hfff,  3, 12'h0f0,  3, 5, 136, 19};
    vecs[5] = '{"stall0", 12'h7ff, 12'hfff, -1, 12'h000,  0, 2, 138, 16};

    load_map(12'hfff, 12'hfff, -1, 12'h000);
    @(negedge frame_clk);
    chk("rst_dots",   dots_left, 144);
    chk("rst_eaten",  eaten, 0);
    chk("rst_lclear", level_clear, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    chk("rst_rdreq",  rd_req, 0);
    chk("rst_rdrow",  rd_row, 0);
    chk("rst_terr",   timeout_err, 0);
    Reset_n = 1'b1;
    repeat (2) @(negedge frame_clk);

    foreach (vecs[v]) begin
      load_map(vecs[v].even_row, vecs[v].odd_row, vecs[v].ovr_row, vecs[v].ovr_val);
      stall_row = vecs[v].st_row;
      stall_len = vecs[v].st_len;
      run_scan(vecs[v].name, vecs[v].exp_dots, vecs[v].exp_lat, 1'b0);
    end
    stall_row = -1;
    stall_len = 0;

    // Second start at scan cycle 4 must not restart or queue a scan.
    load_map(12'hfff, 12'hfff, -1, 12'h000);
    run_scan("start_ign", 144, 14, 1'b1);

    // Stray ack outside REQ must not move the FSM or the results.
    load_map(12'h000, 12'h000, -1, 12'h000);
    run_scan("empty2", 0, 14, 1'b0);
    load_map(12'hfff, 12'hfff, -1, 12'h000);
    d0 = done_cnt;
    force_ack = 1'b1;
    repeat (4) @(negedge frame_clk);
    force_ack = 1'b0;
    repeat (3) @(negedge frame_clk);
    chk("stray_dots",  dots_left, 0);
    chk("stray_done",  done_cnt - d0, 0);
    chk("stray_rdreq", rd_req, 0);
    chk("stray_busy",  busy, 0);

    // Reset in the middle of row 6.
    d0 = done_cnt;
    @(negedge frame_clk);
    start = 1'b1;
    @(negedge frame_clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rd_req && rd_row == 4'd6) begin
        found = 1'b1;
        break;
      end
      @(negedge frame_clk);
    end
    chk("mid_row6_seen", found, 1);
    Reset_n = 1'b0;
    #1;
    chk("mid_rdreq",  rd_req, 0);
    chk("mid_rdrow",  rd_row, 0);
    chk("mid_busy",   busy, 0);
    chk("mid_dots",   dots_left, 144);
    chk("mid_eaten",  eaten, 0);
    chk("mid_lclear", level_clear, 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    repeat (20) @(negedge frame_clk);
    chk("mid_no_done", done_cnt - d0, 0);
    run_scan("after_rst", 144, 14, 1'b0);

`ifdef DOT_MAP_READER_TIMEOUT_EN
    load_map(12'h00f, 12'h00f, -1, 12'h000);
    run_scan("pre_to", 48, 14, 1'b0);
    load_map(12'hfff, 12'hfff, -1, 12'h000);
    stall_row = 2;
    stall_len = 1000;
    d0 = done_cnt;
    n = 0;
    found = 1'b0;
    @(negedge frame_clk);
    start = 1'b1;
    @(negedge frame_clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rd_req && rd_row == 4'd2) n++;
      if (!rd_req && n > 0) begin
        found = 1'b1;
        break;
      end
      @(negedge frame_clk);
    end
    chk("to_dropped", found, 1);
    chk("to_wait_cycles", n, 16);
    chk("to_terr", timeout_err, 1);
    repeat (3) @(negedge frame_clk);
    chk("to_no_done", done_cnt - d0, 0);
    chk("to_dots", dots_left, 48);
    chk("to_busy", busy, 0);
    stall_row = -1;
    stall_len = 0;
    run_scan("after_to", 144, 14, 1'b0);
`else
    chk("terr_tied", timeout_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
